// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 16-requester round-robin mux arbiter.
//   N_REQ   : requester count, fixed to the mux fan-in
//   SEL_W   : mux select width
//   arbState_t : FSM encoding
//   rr_pick : round-robin pick, first requester at or after ptr (mod N_REQ)
package mux_arb_pkg;

  localparam int unsigned N_REQ = 16;
  localparam int unsigned SEL_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arbState_t;

  // Rotate req so that bit ptr lands at position 0, priority-encode the lowest
  // set bit, then add ptr back. The double-width copy makes the rotate a plain shift.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] reqVec,
                                               input logic [SEL_W-1:0] ptrVal);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [SEL_W-1:0]   off;
    dbl = {reqVec, reqVec};
    rot = N_REQ'(dbl >> ptrVal);
    off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[SEL_W'(k)]) off = SEL_W'(k);
    end
    return SEL_W'(ptrVal + off);
  endfunction

endpackage

// File: rtl/rr_pick16.sv
// Combinational round-robin pick over 16 request lines.
//   req : request vector
//   ptr : highest-priority position
//   idx : first set request scanning ptr, ptr+1, ..., wrapping (valid when any=1)
//   any : at least one request is set
module rr_pick16
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  assign idx = rr_pick(req, ptr);
  assign any = |req;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing a 16:1 x 16-bit mux among 16 requesters.
// Each grant carries up to MAX_BURST beats, then priority rotates past the
// granted requester. Back-to-back grants are issued with no idle bubble.
//   clk  : clock, rising edge
//   res  : synchronous active-high reset
//   req  : per-requester request lines
//   rdy  : downstream accepts the mux output this cycle
//   sel  : mux select (registered)
//   gnt  : one-hot grant, zero when idle (registered)
//   vld  : mux output valid (registered)
//   ack  : one-hot transfer pulse to the granted requester
//   busy : arbiter is in GRANT
// MAX_BURST legal range is 1..8.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic [N_REQ-1:0] req,
  input  logic             rdy,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] gnt,
  output logic             vld,
  output logic [N_REQ-1:0] ack,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;

  arbState_t        state, nextState;
  logic [SEL_W-1:0] ptr, nextPtr;
  logic [CNT_W-1:0] beat, nextBeat;
  logic [SEL_W-1:0] nextSel;
  logic [N_REQ-1:0] nextGnt;
  logic             nextVld;

  logic [SEL_W-1:0] pickPtr;
  logic [SEL_W-1:0] pickIdx;
  logic             pickAny;
  logic             xfer;
  logic             lastBeat;
  logic             release_;

  // On release the new priority start is sel+1, so arbitrate from there in the same edge.
  assign pickPtr = (state == ST_GRANT) ? SEL_W'(sel + SEL_W'(1)) : ptr;

  rr_pick16 uPick (
    .req (req),
    .ptr (pickPtr),
    .idx (pickIdx),
    .any (pickAny)
  );

  assign xfer     = vld & rdy;
  assign lastBeat = (beat == CNT_W'(MAX_BURST - 1));
  assign release_ = ~req[sel] | (xfer & lastBeat);

  assign ack  = gnt & {N_REQ{xfer & ~res}};
  assign busy = (state == ST_GRANT);

  // Next-state and output register values.
  always_comb begin
    nextState = state;
    nextPtr   = ptr;
    nextBeat  = beat;
    nextSel   = sel;
    nextGnt   = gnt;
    nextVld   = vld;
    unique case (state)
      ST_IDLE: begin
        if (pickAny) begin
          nextState = ST_GRANT;
          nextSel   = pickIdx;
          nextGnt   = N_REQ'(1) << pickIdx;
          nextVld   = 1'b1;
          nextBeat  = '0;
        end else begin
          nextSel = '0;
          nextGnt = '0;
          nextVld = 1'b0;
        end
      end
      ST_GRANT: begin
        if (release_) begin
          nextPtr  = SEL_W'(sel + SEL_W'(1));
          nextBeat = '0;
          if (pickAny) begin
            nextSel = pickIdx;
            nextGnt = N_REQ'(1) << pickIdx;
            nextVld = 1'b1;
          end else begin
            nextState = ST_IDLE;
            nextSel   = '0;
            nextGnt   = '0;
            nextVld   = 1'b0;
          end
        end else if (xfer) begin
          nextBeat = CNT_W'(beat + CNT_W'(1));
        end
      end
      default: nextState = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (res) begin
      state <= ST_IDLE;
      ptr   <= '0;
      beat  <= '0;
      sel   <= '0;
      gnt   <= '0;
      vld   <= 1'b0;
    end else begin
      state <= nextState;
      ptr   <= nextPtr;
      beat  <= nextBeat;
      sel   <= nextSel;
      gnt   <= nextGnt;
      vld   <= nextVld;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter with MAX_BURST=4.
// Inputs for a cycle are applied at the falling edge; outputs are sampled 1 ns later.
module tb_mux_rr_arbiter;

  logic        clk;
  logic        res;
  logic [15:0] req;
  logic        rdy;
  logic [3:0]  sel;
  logic [15:0] gnt;
  logic        vld;
  logic [15:0] ack;
  logic        busy;

  int total = 0;
  int bad   = 0;

  mux_rr_arbiter #(.MAX_BURST(4)) dut (
    .clk  (clk),
    .res  (res),
    .req  (req),
    .rdy  (rdy),
    .sel  (sel),
    .gnt  (gnt),
    .vld  (vld),
    .ack  (ack),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs, then settle before sampling.
  task automatic cyc(input logic r, input logic [15:0] q, input logic d);
    @(negedge clk);
    res = r;
    req = q;
    rdy = d;
    #1;
  endtask

  // Check all outputs against an expected select/valid/ack.
  task automatic expOut(input string tag, input int eSel, input logic eVld, input logic [15:0] eAck);
    logic [15:0] eGnt;
    eGnt = eVld ? (16'h0001 << eSel) : 16'h0000;
    chk({tag, ".sel"},  32'(sel),  eVld ? 32'(eSel) : 32'd0);
    chk({tag, ".gnt"},  32'(gnt),  32'(eGnt));
    chk({tag, ".vld"},  32'(vld),  32'(eVld));
    chk({tag, ".busy"}, 32'(busy), 32'(eVld));
    chk({tag, ".ack"},  32'(ack),  32'(eAck));
  endtask

  task automatic doReset();
    cyc(1'b1, 16'h0000, 1'b1);
    chk("rst.ack", 32'(ack), 32'd0);
  endtask

  initial begin
    res = 1'b1;
    req = 16'h0000;
    rdy = 1'b0;

    // 1: reset with all requests pending
    cyc(1'b1, 16'hFFFF, 1'b1);
    chk("t1.c0.ack", 32'(ack), 32'd0);
    cyc(1'b1, 16'hFFFF, 1'b1);
    expOut("t1.c1", 0, 1'b0, 16'h0000);
    cyc(1'b0, 16'hFFFF, 1'b0);
    expOut("t1.idle", 0, 1'b0, 16'h0000);
    cyc(1'b0, 16'hFFFF, 1'b0);
    expOut("t1.first", 0, 1'b1, 16'h0000);

    // 2: sole requester 0, continuous rdy; re-granted after rotation
    doReset();
    cyc(1'b0, 16'h0001, 1'b1);
    expOut("t2.idle", 0, 1'b0, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 16'h0001, 1'b1);
      expOut($sformatf("t2.b%0d", i), 0, 1'b1, 16'h0001);
    end
    cyc(1'b0, 16'h0000, 1'b0);
    expOut("t2.drop", 0, 1'b1, 16'h0000);
    cyc(1'b0, 16'h0000, 1'b0);
    expOut("t2.end", 0, 1'b0, 16'h0000);

    // 3: requesters 0 and 15 alternate, 4 beats each, 15 wraps back to 0
    doReset();
    cyc(1'b0, 16'h8001, 1'b1);
    expOut("t3.idle", 0, 1'b0, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 16'h8001, 1'b1);
      expOut($sformatf("t3.g0b%0d", i), 0, 1'b1, 16'h0001);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 16'h8001, 1'b1);
      expOut($sformatf("t3.g15b%0d", i), 15, 1'b1, 16'h8000);
    end
    cyc(1'b0, 16'h8001, 1'b1);
    expOut("t3.wrap", 0, 1'b1, 16'h0001);
    cyc(1'b0, 16'h0000, 1'b0);
    expOut("t3.drop", 0, 1'b1, 16'h0000);
    cyc(1'b0, 16'h0000, 1'b0);
    expOut("t3.end", 0, 1'b0, 16'h0000);

    // 4: grant to 5 held with rdy=0, other lines toggle, then req[5] drops
    doReset();
    cyc(1'b0, 16'h0020, 1'b0);
    expOut("t4.idle", 0, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, (i == 1) ? 16'h0021 : 16'h0020, 1'b0);
      expOut($sformatf("t4.hold%0d", i), 5, 1'b1, 16'h0000);
    end
    cyc(1'b0, 16'h0001, 1'b0);
    expOut("t4.drop", 5, 1'b1, 16'h0000);
    cyc(1'b0, 16'h0001, 1'b0);
    expOut("t4.next", 0, 1'b1, 16'h0000);
    cyc(1'b0, 16'h0000, 1'b0);
    expOut("t4.drop0", 0, 1'b1, 16'h0000);
    cyc(1'b0, 16'h0000, 1'b0);
    expOut("t4.end", 0, 1'b0, 16'h0000);

    // 5: all requesting, continuous rdy: 0..15 then 0, 4 beats each, no bubble
    doReset();
    cyc(1'b0, 16'hFFFF, 1'b1);
    expOut("t5.idle", 0, 1'b0, 16'h0000);
    for (int g = 0; g < 17; g++) begin
      for (int b = 0; b < 4; b++) begin
        cyc(1'b0, 16'hFFFF, 1'b1);
        expOut($sformatf("t5.g%0db%0d", g, b), g % 16, 1'b1, 16'h0001 << (g % 16));
      end
    end
    cyc(1'b0, 16'h0000, 1'b0);
    expOut("t5.drop", 1, 1'b1, 16'h0000);
    cyc(1'b0, 16'h0000, 1'b0);
    expOut("t5.end", 0, 1'b0, 16'h0000);

    // 6: reset mid-burst to 7; ptr back to 0 afterwards
    doReset();
    cyc(1'b0, 16'h0080, 1'b1);
    expOut("t6.idle", 0, 1'b0, 16'h0000);
    cyc(1'b0, 16'h0080, 1'b1);
    expOut("t6.b0", 7, 1'b1, 16'h0080);
    cyc(1'b0, 16'h0080, 1'b1);
    expOut("t6.b1", 7, 1'b1, 16'h0080);
    cyc(1'b1, 16'h0080, 1'b1);
    expOut("t6.rst", 7, 1'b1, 16'h0000);
    cyc(1'b0, 16'hFFFF, 1'b0);
    expOut("t6.after", 0, 1'b0, 16'h0000);
    cyc(1'b0, 16'hFFFF, 1'b0);
    expOut("t6.ptr0", 0, 1'b1, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
